// File: rtl/wb_byte_bridge.sv
// UART-byte-stream to Wishbone bridge.
// Write frame: 0x57, 4 address bytes, 4 data bytes.
// Read frame:  0x52, 4 address bytes.
// Address and data are sent MSB first.
// Replies on tx:
//   0x4B ack (a read ack is followed by 4 read-data bytes, MSB first)
//   0x45 bus timeout
//   0x3F unknown command
module wb_byte_bridge #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] wb_adr_o,
   output logic [31:0] wb_dat_o,
   input  logic [31:0] wb_dat_i,
   output logic [3:0]  wb_sel_o,
   output logic        wb_we_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   input  logic        wb_ack_i,
   output logic        busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   localparam logic [7:0] CMD_WR = 8'h57;
   localparam logic [7:0] CMD_RD = 8'h52;
   localparam logic [7:0] RSP_OK = 8'h4B;
   localparam logic [7:0] RSP_TO = 8'h45;
   localparam logic [7:0] RSP_BAD = 8'h3F;

   typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP, RDATA} state_t;

   state_t        state, state_nxt;
   logic [1:0]    cnt;
   logic          cmd_wr;
   logic          rd_ok;     // current RESP is an ack to a read: read data follows
   logic [31:0]   addr_q, wdat_q, rdat_q;
   logic [TW-1:0] tmo;
   logic [7:0]    tx_q;

   logic rx_fire, tx_fire, bus_ack, bus_tmo, cmd_ok;

   assign rx_fire = rx_valid & rx_ready;
   assign tx_fire = tx_valid & tx_ready;
   // ack has priority over the terminal timeout count
   assign bus_ack = (state == BUS) & wb_ack_i;
   assign bus_tmo = (state == BUS) & ~wb_ack_i & (tmo == TMO_LAST);
   assign cmd_ok  = (rx_data == CMD_WR) | (rx_data == CMD_RD);

   assign rx_ready = (state == IDLE) | (state == ADDR) | (state == DATA);
   assign tx_valid = (state == RESP) | (state == RDATA);
   assign busy     = (state != IDLE);
   assign tx_data  = tx_q;
   assign wb_cyc_o = (state == BUS);
   assign wb_stb_o = (state == BUS);
   assign wb_we_o  = (state == BUS) & cmd_wr;
   assign wb_sel_o = (state == BUS) ? 4'hF : 4'h0;
   assign wb_adr_o = addr_q & 32'hFFFF_FFFC;
   assign wb_dat_o = wdat_q;

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (rx_fire) state_nxt = cmd_ok ? ADDR : RESP;
         ADDR:    if (rx_fire && cnt == 2'd3) state_nxt = cmd_wr ? DATA : BUS;
         DATA:    if (rx_fire && cnt == 2'd3) state_nxt = BUS;
         BUS:     if (bus_ack || bus_tmo) state_nxt = RESP;
         RESP:    if (tx_fire) state_nxt = rd_ok ? RDATA : IDLE;
         RDATA:   if (tx_fire && cnt == 2'd3) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // frame assembly, bus timeout and reply datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         cmd_wr <= 1'b0;
         rd_ok  <= 1'b0;
         addr_q <= '0;
         wdat_q <= '0;
         rdat_q <= '0;
         tmo    <= '0;
         tx_q   <= '0;
      end else begin
         if (state != BUS) tmo <= '0;
         case (state)
            IDLE: if (rx_fire) begin
               cnt   <= '0;
               rd_ok <= 1'b0;
               if (cmd_ok) cmd_wr <= (rx_data == CMD_WR);
               else        tx_q   <= RSP_BAD;
            end
            ADDR: if (rx_fire) begin
               addr_q <= {addr_q[23:0], rx_data};
               cnt    <= cnt + 2'd1;
            end
            DATA: if (rx_fire) begin
               wdat_q <= {wdat_q[23:0], rx_data};
               cnt    <= cnt + 2'd1;
            end
            BUS: begin
               if (wb_ack_i) begin
                  if (!cmd_wr) rdat_q <= wb_dat_i;
                  rd_ok <= ~cmd_wr;
                  tx_q  <= RSP_OK;
               end else if (bus_tmo) begin
                  rd_ok <= 1'b0;
                  tx_q  <= RSP_TO;
               end else begin
                  tmo <= tmo + 1'b1;
               end
            end
            RESP: if (tx_fire && rd_ok) begin
               tx_q   <= rdat_q[31:24];
               rdat_q <= {rdat_q[23:0], 8'h00};
               cnt    <= '0;
            end
            RDATA: if (tx_fire) begin
               tx_q   <= rdat_q[31:24];
               rdat_q <= {rdat_q[23:0], 8'h00};
               cnt    <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/wb_byte_bridge.md
WB_BYTE_BRIDGE -- requirements
Module: wb_byte_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: Wishbone cycles to wait for wb_ack_i before aborting.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 rx_data  in  8  command byte stream from the UART receiver.
REQ-006 rx_valid  in  1 and rx_ready  out  1: a byte transfers on a cycle where both are high.
REQ-007 tx_data  out  8  response byte to the UART transmitter.
REQ-008 tx_valid  out  1 and tx_ready  in  1: a byte transfers on a cycle where both are high.
REQ-009 wb_adr_o  out  32, wb_dat_o  out  32, wb_dat_i  in  32, wb_sel_o  out  4, wb_we_o  out  1, wb_cyc_o  out  1, wb_stb_o  out  1, wb_ack_i  in  1: Wishbone master driving conbus master port m2.
REQ-010 busy  out  1  high in every state except IDLE.

Function
REQ-011 Frame formats: write = 0x57, 4 address bytes, 4 data bytes; read = 0x52, 4 address bytes; address and data are sent MSB first.
REQ-012 States SHALL be IDLE, ADDR, DATA, BUS, RESP and RDATA, with a 2-bit byte counter.
REQ-013 rx_ready SHALL be high only in IDLE, ADDR and DATA; tx_valid SHALL be high only in RESP and RDATA.
REQ-014 IDLE, byte 0x57 or 0x52 accepted: latch the command, clear the counter, go to ADDR.
REQ-015 IDLE, any other byte accepted: load 0x3F into tx_data and go to RESP; the next state after RESP is IDLE.
REQ-016 ADDR: shift each accepted byte into the address register. After the 4th byte, go to DATA for a write or BUS for a read.
REQ-017 DATA: shift each accepted byte into the write-data register. After the 4th byte, go to BUS.
REQ-018 wb_cyc_o and wb_stb_o SHALL assert on the cycle after the final frame byte is accepted and stay high in BUS until ack or timeout.
REQ-019 Bus signals in BUS:
- wb_adr_o = {addr[31:2], 2'b00};
- wb_sel_o = 4'hF;
- wb_we_o = 1 for write, 0 for read;
- wb_dat_o = write-data register.
REQ-020 On the cycle wb_ack_i is high in BUS:
- latch wb_dat_i on a read;
- deassert cyc/stb on the next cycle;
- load 0x4B into tx_data and go to RESP.
REQ-021 The timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-022 When the counter reaches TIMEOUT-1 without ack: drop cyc/stb, load 0x45 into tx_data, go to RESP; no read data bytes follow.
REQ-023 If ack and the timeout terminal count occur on the same cycle, ack SHALL win.
REQ-024 RESP and RDATA: tx_data and tx_valid SHALL stay stable until tx_ready is high.
REQ-025 RESP, after 0x4B for a read: go to RDATA and send the 4 read-data bytes MSB first. Otherwise go to IDLE.
REQ-026 RDATA: after the 4th byte transfers, go to IDLE.
REQ-027 wb_dat_i SHALL be ignored outside the ack cycle, and wb_ack_i SHALL be ignored outside BUS.

Reset
REQ-028 Reset values:
- state IDLE; counters 0;
- wb_cyc_o, wb_stb_o, wb_we_o, tx_valid, busy = 0;
- rx_ready = 1;
- wb_adr_o, wb_dat_o, tx_data = 0; wb_sel_o = 4'h0.
REQ-029 Reset asserted mid-frame or mid-bus-cycle SHALL discard the partial frame and drop cyc/stb on the next edge, with no response byte emitted.

Verification
REQ-030 Write: send 57 40 00 00 08 00 00 00 0F, ack after 2 cycles -> one write with adr 0x40000008, dat 0x0000000F, sel F, we 1; tx emits 4B.
REQ-031 Read: send 52 00 00 01 03, slave returns 0xDEADBEEF with ack -> wb_adr_o = 0x00000100, we 0; tx emits 4B DE AD BE EF.
REQ-032 Timeout: TIMEOUT=16, read to an unacked address -> cyc drops after 16 BUS cycles; tx emits only 45; next command is accepted normally.
REQ-033 Bad command and backpressure:
- send 0x13 -> tx emits 3F, no bus cycle;
- hold tx_ready low 10 cycles during a read reply -> tx_data stable and no bytes lost.
REQ-034 Reset mid-operation: assert reset after the 3rd address byte, then send a full write frame -> only the second frame produces a bus cycle and a 4B reply.
REQ-035 Race: ack on the timeout terminal cycle -> response is 4B, and the read data is returned.
